// File: rtl/password_fsm.sv
// Password entry FSM: collects N_DIGITS digits, checks against PASSWORD, times unlock/error/lockout.
// Latency: flags rise one cycle after the final digit is captured (one CHECK cycle).
// Backpressure: none; pulses outside ENTRY are dropped, never buffered.
module password_fsm #(
    parameter int unsigned                  N_DIGITS    = 4,
    parameter int unsigned                  DIGIT_W     = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0]  PASSWORD    = 16'h1234,
    parameter int unsigned                  MAX_FAILS   = 3,
    parameter int unsigned                  OPEN_CYCLES = 50_000_000,
    parameter int unsigned                  ERR_CYCLES  = 25_000_000,
    parameter int unsigned                  LOCK_CYCLES = 250_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              enter_pulse,
    input  logic                              clear_pulse,
    output logic                              unlocked,
    output logic                              error,
    output logic                              locked_out,
    output logic [$clog2(N_DIGITS+1)-1:0]     digit_count,
    output logic [7:0]                        fail_count
);

    localparam int unsigned CW    = $clog2(N_DIGITS + 1);
    localparam int unsigned SRW   = N_DIGITS * DIGIT_W;
    localparam int unsigned T_MAX = (OPEN_CYCLES > ERR_CYCLES)
                                    ? ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES)
                                    : ((ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES);
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ERR_LAST  = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(N_DIGITS - 1);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t         state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     fail_q, fail_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     fail_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ENTRY;
            sr_q    <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign fail_inc = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            S_ENTRY: begin
                // clear takes priority so a colliding digit is dropped
                if (clear_pulse) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (enter_pulse) begin
                    sr_d  = (sr_q << DIGIT_W) | SRW'(digit_in);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                timer_d = '0;
                cnt_d   = '0;
                sr_d    = '0;
                if (sr_q == PASSWORD) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                end else if (({1'b0, fail_q} + 9'd1) >= 9'(MAX_FAILS)) begin
                    state_d = S_LOCKOUT;
                    fail_d  = fail_inc;
                end else begin
                    state_d = S_FAIL;
                    fail_d  = fail_inc;
                end
            end
            S_OPEN: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == OPEN_LAST) state_d = S_ENTRY;
            end
            S_FAIL: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == ERR_LAST) state_d = S_ENTRY;
            end
            S_LOCKOUT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == LOCK_LAST) begin
                    state_d = S_ENTRY;
                    fail_d  = '0;
                end
            end
            default: state_d = S_ENTRY;
        endcase
    end

    assign unlocked    = (state_q == S_OPEN);
    assign error       = (state_q == S_FAIL);
    assign locked_out  = (state_q == S_LOCKOUT);
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_password_fsm.sv
// Bench for password_fsm: attempt-level reference model feeds a queue; a monitor checks each flag window.
module tb_password_fsm;

    localparam int          OPEN_C = 4;
    localparam int          ERR_C  = 3;
    localparam int          LOCK_C = 8;
    localparam int          MAXF   = 3;
    localparam logic [15:0] PW     = 16'h1234;
    localparam logic [2:0]  K_OPEN = 3'b001;
    localparam logic [2:0]  K_FAIL = 3'b010;
    localparam logic [2:0]  K_LOCK = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] digit_in = '0;
    logic       enter_pulse = 1'b0;
    logic       clear_pulse = 1'b0;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_count;
    logic [7:0] fail_count;

    always #5 clk = ~clk;

    password_fsm #(
        .N_DIGITS(4), .DIGIT_W(4), .PASSWORD(PW), .MAX_FAILS(MAXF),
        .OPEN_CYCLES(OPEN_C), .ERR_CYCLES(ERR_C), .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in),
        .enter_pulse(enter_pulse), .clear_pulse(clear_pulse),
        .unlocked(unlocked), .error(error), .locked_out(locked_out),
        .digit_count(digit_count), .fail_count(fail_count)
    );

    typedef struct {
        logic [2:0] kind;
        int         dur;
        int         fc;
        int         rise;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   model_fails = 0;
    bit   mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: one completed code attempt -> one flag window.
    task automatic model_attempt(input logic [15:0] code, input int rise, output exp_t e);
        int nf;
        e.rise = rise;
        if (code == PW) begin
            e.kind = K_OPEN; e.dur = OPEN_C; e.fc = 0;
            model_fails = 0;
        end else begin
            nf = (model_fails >= 255) ? 255 : model_fails + 1;
            e.fc = nf;
            if (model_fails + 1 >= MAXF) begin
                e.kind = K_LOCK; e.dur = LOCK_C;
                model_fails = 0;
            end else begin
                e.kind = K_FAIL; e.dur = ERR_C;
                model_fails = nf;
            end
        end
    endtask

    bit   active = 1'b0;
    int   win_len = 0;
    exp_t cur;

    always @(negedge clk) begin
        logic [2:0] fl;
        fl = {locked_out, error, unlocked};
        if (!mon_en || !rst) begin
            active = 1'b0;
        end else if (active) begin
            if (fl == cur.kind) begin
                win_len++;
            end else begin
                chk("window_length", win_len, cur.dur);
                active = 1'b0;
                if (fl != 3'b000) chk("flags_after_window", int'(fl), 0);
            end
        end else if (fl != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_flags", int'(fl), 0);
            end else begin
                cur = exp_q.pop_front();
                chk("flag_kind", int'(fl), int'(cur.kind));
                chk("rise_cycle", cyc, cur.rise);
                chk("window_fail_count", int'(fail_count), cur.fc);
                active  = 1'b1;
                win_len = 1;
            end
        end
    end

    task automatic press(input logic [3:0] d, input bit en, input bit clr, input int exp_cnt);
        digit_in    = d;
        enter_pulse = en;
        clear_pulse = clr;
        @(negedge clk);
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        chk("digit_count", int'(digit_count), exp_cnt);
    endtask

    // noise: 0 quiet, 1 random pulses, 2 enter_pulse every cycle while busy
    task automatic attempt(input logic [15:0] code, input int noise);
        exp_t e;
        int   drive;
        drive = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) drive = cyc;
            press(code[15-4*i -: 4], 1'b1, 1'b0, i + 1);
            if (i < 3) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        model_attempt(code, drive + 2, e);
        exp_q.push_back(e);
        for (int j = 0; j <= e.dur; j++) begin
            if (noise == 1) begin
                enter_pulse = 1'($urandom_range(0, 1));
                clear_pulse = 1'($urandom_range(0, 1));
                digit_in    = 4'($urandom);
            end else if (noise == 2) begin
                enter_pulse = 1'b1;
                digit_in    = 4'($urandom);
            end
            @(negedge clk);
        end
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        @(negedge clk);
        chk("idle_flags", int'({locked_out, error, unlocked}), 0);
        chk("idle_digit_count", int'(digit_count), 0);
        chk("idle_fail_count", int'(fail_count), model_fails);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] code;
        int          k;

        repeat (2) @(negedge clk);
        chk("reset_flags", int'({locked_out, error, unlocked}), 0);
        chk("reset_digit_count", int'(digit_count), 0);
        chk("reset_fail_count", int'(fail_count), 0);
        rst = 1'b1;
        @(negedge clk);

        attempt(PW, 0);
        attempt(16'h1235, 0);
        attempt(PW, 0);
        attempt(16'h1235, 1);
        attempt(16'h0000, 1);
        attempt(16'hFFFF, 1);

        press(4'd1, 1'b1, 1'b0, 1);
        press(4'd2, 1'b1, 1'b0, 2);
        press(4'd0, 1'b0, 1'b1, 0);
        press(4'd7, 1'b1, 1'b1, 0);
        attempt(PW, 0);
        attempt(PW, 2);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) press(4'($urandom), 1'b1, 1'b0, i + 1);
                press(4'($urandom), 1'($urandom_range(0, 1)), 1'b1, 0);
            end
            case ($urandom_range(0, 2))
                0:       code = PW;
                1:       code = PW ^ (16'h1 << $urandom_range(0, 15));
                default: code = 16'($urandom);
            endcase
            attempt(code, int'($urandom_range(0, 2)));
        end

        // asynchronous reset during partial entry with a nonzero fail count
        attempt(16'h4321, 0);
        if (model_fails == 0) attempt(16'h4321, 0);
        press(4'd1, 1'b1, 1'b0, 1);
        press(4'd2, 1'b1, 1'b0, 2);
        #2 rst = 1'b0;
        #1;
        chk("async_entry_digit_count", int'(digit_count), 0);
        chk("async_entry_fail_count", int'(fail_count), 0);
        @(negedge clk);
        rst = 1'b1;
        model_fails = 0;
        @(negedge clk);

        // asynchronous reset mid-OPEN
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) press(PW[15-4*i -: 4], 1'b1, 1'b0, i + 1);
        repeat (2) @(negedge clk);
        chk("open_before_reset", int'(unlocked), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_open_flags", int'({locked_out, error, unlocked}), 0);
        chk("async_open_digit_count", int'(digit_count), 0);
        chk("async_open_fail_count", int'(fail_count), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_flags", int'({locked_out, error, unlocked}), 0);
        chk("post_reset_digit_count", int'(digit_count), 0);
        mon_en = 1'b1;
        attempt(PW, 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
